// File: rtl/parallel2serial.sv
// Parallel-to-serial transmitter: accepts WIDTH-bit words over valid/ready and
// emits them one bit per clock, with a one-word hold buffer for gapless streaming.
module parallel2serial #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_parallel,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout_serial,
  output logic             dout_valid,
  output logic             dout_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sreg_r, sreg_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] hold_data_r, hold_data_s;
  logic             hold_valid_r, hold_valid_s;
  logic             last_r, last_s;
  logic             acc_s;

  // Move the shifter one position toward the output end, zero-filling behind.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  assign acc_s = din_valid && !hold_valid_r;

  // Next-state, shifter, counter and hold-buffer update.
  always_comb begin
    state_s      = state_r;
    sreg_s       = sreg_r;
    cnt_s        = cnt_r;
    hold_data_s  = hold_data_r;
    hold_valid_s = hold_valid_r;
    case (state_r)
      IDLE: begin
        if (acc_s) begin
          sreg_s  = din_parallel;
          cnt_s   = CNT_ZERO;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r != CNT_LAST) begin
          sreg_s = shift_out(sreg_r);
          cnt_s  = cnt_r + CNT_ONE;
          if (acc_s) begin
            hold_data_s  = din_parallel;
            hold_valid_s = 1'b1;
          end else begin
            hold_valid_s = hold_valid_r;
          end
        end else if (hold_valid_r) begin
          sreg_s       = hold_data_r;
          cnt_s        = CNT_ZERO;
          hold_valid_s = 1'b0;
        end else if (acc_s) begin
          sreg_s = din_parallel;
          cnt_s  = CNT_ZERO;
        end else begin
          // Clearing the shifter keeps dout_serial at 0 while idle.
          sreg_s  = {WIDTH{1'b0}};
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
        end
      end
      default: begin
        state_s      = IDLE;
        sreg_s       = {WIDTH{1'b0}};
        cnt_s        = CNT_ZERO;
        hold_valid_s = 1'b0;
      end
    endcase
    last_s = (state_s == SHIFT) && (cnt_s == CNT_LAST);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      sreg_r       <= {WIDTH{1'b0}};
      cnt_r        <= CNT_ZERO;
      hold_data_r  <= {WIDTH{1'b0}};
      hold_valid_r <= 1'b0;
      last_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      sreg_r       <= sreg_s;
      cnt_r        <= cnt_s;
      hold_data_r  <= hold_data_s;
      hold_valid_r <= hold_valid_s;
      last_r       <= last_s;
    end
  end

  assign dout_serial = MSB_FIRST ? sreg_r[WIDTH-1] : sreg_r[0];
  assign dout_valid  = (state_r == SHIFT);
  assign dout_last   = last_r;
  assign din_ready   = !hold_valid_r;

endmodule

// File: tb/tb_parallel2serial.sv
// Scoreboard bench for parallel2serial: accepted words are queued by the driver and
// a negedge monitor reassembles the serial stream and compares word by word.
module tb_parallel2serial;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din_parallel;
  logic       din_valid;
  logic       din_ready;
  logic       dout_serial;
  logic       dout_valid;
  logic       dout_last;

  logic [7:0] l_din_parallel;
  logic       l_din_valid;
  logic       l_din_ready;
  logic       l_dout_serial;
  logic       l_dout_valid;
  logic       l_dout_last;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb[$];
  logic [7:0] rx = 8'd0;
  int         rx_cnt = 0;

  always #5 clk = ~clk;

  parallel2serial #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din_parallel(din_parallel), .din_valid(din_valid),
    .din_ready(din_ready), .dout_serial(dout_serial), .dout_valid(dout_valid),
    .dout_last(dout_last)
  );

  parallel2serial #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din_parallel(l_din_parallel), .din_valid(l_din_valid),
    .din_ready(l_din_ready), .dout_serial(l_dout_serial), .dout_valid(l_dout_valid),
    .dout_last(l_dout_last)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present one word and hold it until accepted; reports rejected cycles.
  task automatic send(input logic [7:0] w, output int waits);
    logic rdy;
    waits = 0;
    din_parallel = w;
    din_valid    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rdy = din_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        sb.push_back(w);
        return;
      end
      waits++;
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && rx_cnt == 0 && !dout_valid) return;
      @(posedge clk);
      #1;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: reassemble MSB-first words and compare against the scoreboard.
  always @(negedge clk) begin
    logic [7:0] exp_w;
    if (rst) begin
      rx_cnt = 0;
      sb.delete();
    end else begin
      if (dout_last && !dout_valid) check("last_without_valid", 1, 0);
      if (dout_valid) begin
        if (sb.size() == 0) begin
          check("spurious_bit", 1, 0);
        end else begin
          rx = {rx[6:0], dout_serial};
          rx_cnt++;
          if (dout_last || rx_cnt == 8) begin
            exp_w = sb.pop_front();
            check("word_data", rx, exp_w);
            check("last_position", rx_cnt, 8);
            check("last_flag", dout_last, 1);
            rx_cnt = 0;
          end
        end
      end else if (sb.size() != 0) begin
        check("gap_cycle", dout_valid, 1);
      end
    end
  end

  initial begin
    int w;
    rst            = 1'b1;
    din_valid      = 1'b0;
    din_parallel   = 8'h00;
    l_din_valid    = 1'b0;
    l_din_parallel = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", dout_valid, 0);
    check("reset_serial", dout_serial, 0);
    check("reset_last", dout_last, 0);
    check("reset_ready", din_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word 0xA5, latency one, idle after eight bits.
    send(8'hA5, w);
    din_valid = 1'b0;
    check("latency1_valid", dout_valid, 1);
    check("latency1_bit", dout_serial, 1);
    repeat (8) @(posedge clk);
    #1;
    check("idle_valid", dout_valid, 0);
    check("idle_serial", dout_serial, 0);
    check("idle_ready", din_ready, 1);
    wait_drain(20);

    // Back-to-back stream: 0xA5, 0x3C, 0xFF.
    send(8'hA5, w);
    send(8'h3C, w);
    send(8'hFF, w);
    din_valid = 1'b0;
    wait_drain(40);

    // Hold buffer: 0x11 shifts, 0x22 held, 0x33 waits for the hold to drain.
    send(8'h11, w);
    send(8'h22, w);
    check("hold_accept_wait", w, 0);
    check("ready_low_after_hold", din_ready, 0);
    send(8'h33, w);
    check("ready_low_cycles", w, 7);
    din_valid = 1'b0;
    wait_drain(40);

    // Reset mid-word: 0xC3 shifting, 0x5A held, reset on bit 3.
    send(8'hC3, w);
    send(8'h5A, w);
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_valid", dout_valid, 0);
    check("rst_mid_serial", dout_serial, 0);
    check("rst_mid_last", dout_last, 0);
    check("rst_mid_ready", din_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    check("rst_no_held_word", dout_valid, 0);
    send(8'h81, w);
    din_valid = 1'b0;
    wait_drain(20);

    // LSB-first instance: 0x01 gives 1 then seven zeros.
    l_din_parallel = 8'h01;
    l_din_valid    = 1'b1;
    @(posedge clk);
    #1;
    l_din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb_valid", l_dout_valid, 1);
      check("lsb_bit", l_dout_serial, (i == 0) ? 1 : 0);
      check("lsb_last", l_dout_last, (i == 7) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    check("lsb_idle", l_dout_valid, 0);

    // Sixteen random words streamed back-to-back.
    for (int k = 0; k < 16; k++) begin
      send(8'($urandom_range(0, 255)), w);
    end
    din_valid = 1'b0;
    wait_drain(200);
    check("final_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
